// File: rtl/issue_scoreboard.sv
// In-order issue controller: scoreboard of pending register writes, hazard
// detection (RAW/WAW/multiplier/writeback port) and writeback slot scheduling.
module issue_scoreboard #(
  parameter int ALU_LAT = 1,
  parameter int LSU_LAT = 2,
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_rd,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_imm_flag,
  input  logic       is_branch_taken,
  output logic       stall,
  output logic       issue_valid,
  output logic [1:0] issue_unit,
  output logic [3:0] issue_opcode,
  output logic [2:0] issue_rd,
  output logic [7:0] busy_mask,
  output logic       wb_valid,
  output logic [2:0] wb_rd
);

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_LSU = 2'd2;
  localparam logic [1:0] UNIT_BR  = 2'd3;

  logic [7:0] r_busy;
  logic [6:0] r_resValid;
  logic [2:0] r_resRd [7];
  logic [2:0] r_mulCnt;
  logic       r_issueValid;
  logic [1:0] r_issueUnit;
  logic [3:0] r_issueOpcode;
  logic [2:0] r_issueRd;

  logic       w_isNop, w_isMul, w_isLsu, w_isBr, w_writesRd, w_reserves;
  logic [1:0] w_unit;
  logic [2:0] w_lat;
  logic [7:0] w_wbClear, w_effBusy, w_resExt, w_busyNext;
  logic       w_raw, w_waw, w_mulBusy, w_wbConflict, w_hazard, w_accept, w_issue;
  logic [6:0] w_resValidNext;
  logic [2:0] w_resRdNext [7];

  assign w_isNop    = (id_opcode == 4'h0);
  assign w_isMul    = (id_opcode == 4'hA) || (id_opcode == 4'hB);
  assign w_isLsu    = (id_opcode == 4'hC);
  assign w_isBr     = (id_opcode >= 4'hD);
  assign w_unit     = w_isMul ? UNIT_MUL : w_isLsu ? UNIT_LSU : w_isBr ? UNIT_BR : UNIT_ALU;
  assign w_lat      = w_isMul ? 3'(MUL_LAT) : w_isLsu ? 3'(LSU_LAT) : 3'(ALU_LAT);
  assign w_writesRd = !w_isNop && !w_isBr;
  // r0 writes use no writeback port, so they neither reserve nor conflict
  assign w_reserves = w_writesRd && (id_rd != 3'd0);

  assign wb_valid  = r_resValid[0];
  assign wb_rd     = r_resRd[0];
  assign w_wbClear = wb_valid ? (8'b1 << wb_rd) : 8'b0;
  assign w_effBusy = r_busy & ~w_wbClear;
  assign w_resExt  = {1'b0, r_resValid};

  assign w_raw        = w_effBusy[id_rs1] || (!id_imm_flag && w_effBusy[id_rs2]);
  assign w_waw        = w_writesRd && w_effBusy[id_rd];
  assign w_mulBusy    = w_isMul && (r_mulCnt != 3'd0);
  assign w_wbConflict = w_reserves && w_resExt[w_lat];
  assign w_hazard     = id_valid && !w_isNop && (w_raw || w_waw || w_mulBusy || w_wbConflict);

  assign stall    = w_hazard && !is_branch_taken && !reset;
  assign w_accept = id_valid && !w_hazard && !is_branch_taken && !reset;
  assign w_issue  = w_accept && !w_isNop;

  // Shift reservations toward the head; a new reservation lands at L-1 so it
  // reaches the head exactly L cycles after acceptance.
  always_comb begin
    w_busyNext = r_busy & ~w_wbClear;
    if (w_issue && w_reserves) w_busyNext[id_rd] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w_resValidNext[i] = r_resValid[i+1];
      w_resRdNext[i]    = r_resRd[i+1];
    end
    w_resValidNext[6] = 1'b0;
    w_resRdNext[6]    = 3'd0;
    if (w_issue && w_reserves) begin
      w_resValidNext[w_lat - 3'd1] = 1'b1;
      w_resRdNext[w_lat - 3'd1]    = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy        <= 8'd0;
      r_resValid    <= 7'd0;
      for (int i = 0; i < 7; i++) r_resRd[i] <= 3'd0;
      r_mulCnt      <= 3'd0;
      r_issueValid  <= 1'b0;
      r_issueUnit   <= 2'd0;
      r_issueOpcode <= 4'd0;
      r_issueRd     <= 3'd0;
    end else begin
      r_busy     <= w_busyNext;
      r_resValid <= w_resValidNext;
      for (int i = 0; i < 7; i++) r_resRd[i] <= w_resRdNext[i];
      if (w_issue && w_isMul)
        r_mulCnt <= 3'(MUL_LAT - 1);
      else if (r_mulCnt != 3'd0)
        r_mulCnt <= r_mulCnt - 3'd1;
      r_issueValid <= w_issue;
      if (w_issue) begin
        r_issueUnit   <= w_unit;
        r_issueOpcode <= id_opcode;
        r_issueRd     <= id_rd;
      end
    end
  end

  assign issue_valid  = r_issueValid;
  assign issue_unit   = r_issueUnit;
  assign issue_opcode = r_issueOpcode;
  assign issue_rd     = r_issueRd;
  assign busy_mask    = r_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table for the corner-case
// sequences, then random traffic against a writeback-schedule reference model.
module tb_issue_scoreboard;

  localparam int ALU_LAT = 1;
  localparam int LSU_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int NCYC    = 8192;

  logic       clk = 1'b0;
  logic       reset, id_valid, id_imm_flag, is_branch_taken;
  logic [3:0] id_opcode;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic       stall, issue_valid, wb_valid;
  logic [1:0] issue_unit;
  logic [3:0] issue_opcode;
  logic [2:0] issue_rd, wb_rd;
  logic [7:0] busy_mask;

  always #5 clk = ~clk;

  issue_scoreboard #(.ALU_LAT(ALU_LAT), .LSU_LAT(LSU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm_flag(id_imm_flag),
    .is_branch_taken(is_branch_taken), .stall(stall), .issue_valid(issue_valid),
    .issue_unit(issue_unit), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
    .busy_mask(busy_mask), .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic       imm, br, rst;
    logic       eStall, eIv, eWbV;
    logic [2:0] eWbRd;
    logic [7:0] eBusy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Reference model: absolute-cycle writeback schedule, multiplier free time
  bit         schedV  [NCYC];
  logic [2:0] schedRd [NCYC];
  int         mulFreeAt;
  bit         expIv;
  logic [1:0] expUnit;
  logic [3:0] expOp;
  logic [2:0] expRd;

  vec_t tbl[$];

  function automatic vec_t mk(int v, int op, int rd, int rs1, int rs2, int imm, int br, int rst,
                              int eStall, int eIv, int eWbV, int eWbRd, int eBusy);
    vec_t r;
    r.v = 1'(v); r.op = 4'(op); r.rd = 3'(rd); r.rs1 = 3'(rs1); r.rs2 = 3'(rs2);
    r.imm = 1'(imm); r.br = 1'(br); r.rst = 1'(rst);
    r.eStall = 1'(eStall); r.eIv = 1'(eIv); r.eWbV = 1'(eWbV);
    r.eWbRd = 3'(eWbRd); r.eBusy = 8'(eBusy);
    return r;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic applyStimulus(input vec_t s);
    id_valid        = s.v;
    id_opcode       = s.op;
    id_rd           = s.rd;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_imm_flag     = s.imm;
    is_branch_taken = s.br;
    reset           = s.rst;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against model (and table row), advance model
  task automatic stepCycle(input vec_t s, input bit useTable);
    logic [7:0] busyExp, eff;
    bit         wbV, nop, mul, lsu, isBr, writes, rsv, haz, expStall, acc;
    logic [2:0] wbRd;
    int         lat;
    applyStimulus(s);
    @(negedge clk);
    wbV  = schedV[cyc];
    wbRd = schedRd[cyc];
    busyExp = 8'd0;
    for (int m = cyc; m < cyc + 8; m++)
      if (schedV[m]) busyExp[schedRd[m]] = 1'b1;
    eff = busyExp;
    if (wbV) eff[wbRd] = 1'b0;
    nop    = (s.op == 4'h0);
    mul    = (s.op == 4'hA) || (s.op == 4'hB);
    lsu    = (s.op == 4'hC);
    isBr   = (s.op >= 4'hD);
    lat    = mul ? MUL_LAT : (lsu ? LSU_LAT : ALU_LAT);
    writes = !nop && !isBr;
    rsv    = writes && (s.rd != 0);
    haz = s.v && !nop && (eff[s.rs1] || (!s.imm && eff[s.rs2]) || (writes && eff[s.rd]) ||
          (mul && cyc < mulFreeAt) || (rsv && schedV[cyc + lat]));
    expStall = haz && !s.br && !s.rst;

    checkOutput("stall", 8'(stall), 8'(expStall));
    checkOutput("issue_valid", 8'(issue_valid), 8'(expIv));
    if (expIv) begin
      checkOutput("issue_unit", 8'(issue_unit), 8'(expUnit));
      checkOutput("issue_opcode", 8'(issue_opcode), 8'(expOp));
      checkOutput("issue_rd", 8'(issue_rd), 8'(expRd));
    end
    checkOutput("busy_mask", busy_mask, busyExp);
    checkOutput("wb_valid", 8'(wb_valid), 8'(wbV));
    if (wbV) checkOutput("wb_rd", 8'(wb_rd), 8'(wbRd));
    if (useTable) begin
      checkOutput("tbl_stall", 8'(stall), 8'(s.eStall));
      checkOutput("tbl_issue_valid", 8'(issue_valid), 8'(s.eIv));
      checkOutput("tbl_busy_mask", busy_mask, s.eBusy);
      checkOutput("tbl_wb_valid", 8'(wb_valid), 8'(s.eWbV));
      if (s.eWbV) checkOutput("tbl_wb_rd", 8'(wb_rd), 8'(s.eWbRd));
    end

    @(posedge clk);
    #1;
    acc = s.v && !expStall && !s.br && !s.rst;
    if (s.rst) begin
      for (int m = cyc + 1; m < cyc + 10; m++) schedV[m] = 1'b0;
      mulFreeAt = 0;
      expIv = 1'b0; expUnit = 2'd0; expOp = 4'd0; expRd = 3'd0;
    end else begin
      expIv = acc && !nop;
      if (acc && !nop) begin
        expUnit = mul ? 2'd1 : (lsu ? 2'd2 : (isBr ? 2'd3 : 2'd0));
        expOp   = s.op;
        expRd   = s.rd;
        if (rsv) begin
          schedV[cyc + lat]  = 1'b1;
          schedRd[cyc + lat] = s.rd;
        end
        if (mul) mulFreeAt = cyc + MUL_LAT;
      end
    end
    cyc++;
  endtask

  initial begin
    vec_t r;
    cyc = 0;
    mulFreeAt = 0;
    expIv = 1'b0; expUnit = 2'd0; expOp = 4'd0; expRd = 3'd0;
    for (int m = 0; m < NCYC; m++) begin schedV[m] = 1'b0; schedRd[m] = 3'd0; end

    r = idle();
    r.rst = 1'b1;
    applyStimulus(r);
    @(posedge clk);
    #1;
    checkOutput("rst_stall", 8'(stall), 8'd0);
    checkOutput("rst_issue_valid", 8'(issue_valid), 8'd0);
    checkOutput("rst_issue_unit", 8'(issue_unit), 8'd0);
    checkOutput("rst_issue_opcode", 8'(issue_opcode), 8'd0);
    checkOutput("rst_issue_rd", 8'(issue_rd), 8'd0);
    checkOutput("rst_busy_mask", busy_mask, 8'd0);
    checkOutput("rst_wb_valid", 8'(wb_valid), 8'd0);
    checkOutput("rst_wb_rd", 8'(wb_rd), 8'd0);
    stepCycle(r, 1'b0);
    stepCycle(idle(), 1'b0);
    stepCycle(idle(), 1'b0);

    //           v op    rd rs1 rs2 imm br rst  stall iv wbv wbrd busy
    // ALU bypass
    tbl.push_back(mk(1, 'h2, 3, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h1, 4, 3, 0, 1, 0, 0,   0, 1, 1, 3, 'h08));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 1, 4, 'h10));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // MUL RAW through rs2
    tbl.push_back(mk(1, 'hA, 5, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h3, 6, 0, 5, 0, 0, 0,   1, 1, 0, 0, 'h20));
    tbl.push_back(mk(1, 'h3, 6, 0, 5, 0, 0, 0,   1, 0, 0, 0, 'h20));
    tbl.push_back(mk(1, 'h3, 6, 0, 5, 0, 0, 0,   0, 0, 1, 5, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 1, 6, 'h40));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // Same with immediate: rs2 ignored
    tbl.push_back(mk(1, 'hA, 5, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h3, 6, 0, 5, 1, 0, 0,   0, 1, 0, 0, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 1, 6, 'h60));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // Writeback port conflict
    tbl.push_back(mk(1, 'hA, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'hC, 2, 0, 0, 1, 0, 0,   1, 1, 0, 0, 'h02));
    tbl.push_back(mk(1, 'hC, 2, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h02));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 'h06));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1, 2, 'h04));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // Flush of a RAW-stalled instruction
    tbl.push_back(mk(1, 'hA, 5, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h1, 6, 5, 0, 1, 1, 0,   0, 1, 0, 0, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 'h20));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // r0 is never busy and never written back
    tbl.push_back(mk(1, 'h1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h1, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // Back-to-back independent MULs
    tbl.push_back(mk(1, 'hB, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'hA, 2, 0, 0, 1, 0, 0,   1, 1, 0, 0, 'h02));
    tbl.push_back(mk(1, 'hA, 2, 0, 0, 1, 0, 0,   1, 0, 0, 0, 'h02));
    tbl.push_back(mk(1, 'hA, 2, 0, 0, 1, 0, 0,   0, 0, 1, 1, 'h02));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 'h04));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h04));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1, 2, 'h04));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    // Reset with a MUL in flight drops its writeback
    tbl.push_back(mk(1, 'hA, 4, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 'h1, 6, 4, 0, 1, 0, 1,   0, 1, 0, 0, 'h10));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));

    foreach (tbl[i]) stepCycle(tbl[i], 1'b1);

    for (int n = 0; n < 3000; n++) begin
      r = idle();
      r.v   = ($urandom_range(0, 9) != 0);
      r.op  = 4'($urandom);
      r.rd  = 3'($urandom);
      r.rs1 = 3'($urandom);
      r.rs2 = 3'($urandom);
      r.imm = 1'($urandom);
      r.br  = ($urandom_range(0, 15) == 0);
      r.rst = ($urandom_range(0, 255) == 0);
      stepCycle(r, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between the decode unit and the execution units. Tracks pending register writes in an 8-entry scoreboard and checks each decoded instruction for RAW/WAW hazards, a busy non-pipelined multiplier and writeback-port conflicts. Issues the instruction to its unit or drives `stall` back to decode. Honours `is_branch_taken` flushes, and schedules the single shared writeback port with a reservation shift register.

## Interface
- `ALU_LAT`, 1: ALU latency in cycles from accept to writeback (range 1..7).
- `LSU_LAT`, 2: load/store latency; the LSU is pipelined (range 1..7).
- `MUL_LAT`, 3: multiplier latency; the multiplier is not pipelined (range 1..7).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decoded instruction present this cycle.
- `id_opcode`  in  4  decoded opcode.
- `id_rd`  in  3  destination register.
- `id_rs1`  in  3  source register 1.
- `id_rs2`  in  3  source register 2.
- `id_imm_flag`  in  1  when set, rs2 is unused and ignored for hazards.
- `is_branch_taken`  in  1  flush request from branch resolution.
- `stall`  out  1  combinational; decode must hold its instruction.
- `issue_valid`  out  1  registered; instruction issued this cycle.
- `issue_unit`  out  2  target unit: 0 = ALU, 1 = MUL, 2 = LSU, 3 = BR.
- `issue_opcode`  out  4  registered copy of the accepted opcode.
- `issue_rd`  out  3  registered copy of the accepted rd.
- `busy_mask`  out  8  scoreboard; bit r set while r has a pending write.
- `wb_valid`  out  1  writeback occurring this cycle.
- `wb_rd`  out  3  register being written back.

## Operation
- **Opcode classes:**
  - 0x0: NOP. Accepted, never stalls, no issue.
  - 0x1–0x9: ALU, writes rd.
  - 0xA–0xB: MUL, writes rd.
  - 0xC: LSU load, writes rd.
  - 0xD–0xF: BR. Reads rs1/rs2, no rd, no writeback.
- **r0:** hardwired zero.
  - Never marked busy.
  - Reads of r0 never hazard.
  - Writes to r0 issue normally but reserve no writeback slot.
- **Effective busy:** register r is effectively busy when `busy_mask[r]` is set and not (`wb_valid` and `wb_rd`==r) in the same cycle. This gives writeback bypass.
- **Hazard conditions** (evaluated only when `id_valid`, not NOP, not flushing):
  - RAW: rs1 effectively busy, or rs2 effectively busy with `id_imm_flag`=0.
  - WAW: instruction writes rd and rd is effectively busy.
  - MUL structural: MUL op and multiplier countdown ≠ 0.
  - WB conflict: the writeback slot at the op's latency L is already reserved.
- **Stall:** `stall` = any hazard condition, and 0 when `is_branch_taken`=1 or `reset`=1.
- **Accept:** `id_valid` & !stall & !`is_branch_taken` & !`reset`. A non-NOP accept:
  - loads the issue_* registers;
  - sets `busy_mask[rd]` (if it writes a non-zero rd);
  - reserves slot L with rd;
  - for MUL, loads the countdown with MUL_LAT-1.
- **Reservation pipeline:** depth 7. Advances one position per cycle. The head entry drives `wb_valid`/`wb_rd` and clears `busy_mask[wb_rd]` at the end of that cycle.
- **Set/clear collision:** if an accept sets the same register that writeback is clearing in that cycle, the set wins.
- **Flush:** the presented instruction is discarded. Already-issued ops still complete, and their busy bits and reservations persist.
- **MUL countdown:** decrements by 1 per cycle while non-zero.

## Timing
- **Accept to issue and writeback:** accept in cycle t gives `issue_valid`=1 in cycle t+1, and `wb_valid`=1 in cycle t+L (ALU_LAT, LSU_LAT or MUL_LAT). BR ops have no writeback.
- **Back-to-back dependence:** with ALU_LAT=1, a dependent ALU op presented in t+1 issues without stall (bypass).
- **MUL dependence:** a dependent of a MUL accepted at t stalls cycles t+1..t+MUL_LAT-1 and is accepted in t+MUL_LAT.
- **MUL occupancy:** a second MUL stalls MUL_LAT-1 cycles.
- **`issue_valid` deassertion:** `issue_valid` is 0 in the cycle after any non-accept (stall, flush, NOP, `id_valid`=0).
- **Reset:** synchronous reset clears all state. It takes effect at the next edge, including mid-operation, and in-flight writebacks are dropped.
  - Registered outputs reset to 0: `issue_valid`, `issue_unit`, `issue_opcode`, `issue_rd`, `busy_mask`, `wb_valid`, `wb_rd`.
  - Internal state reset to 0: reservations and the MUL countdown.
  - `stall` is 0 while `reset` is high.

## Test plan
- **Reset:** hold `reset` 2 cycles after issuing a MUL to r4 -> `busy_mask`=0x00, `wb_valid` never asserts, `stall`=0, `issue_valid`=0.
- **ALU bypass:**
  - Stimulus: ALU opcode 0x2 rd=3 at t, then ALU rs1=3 at t+1.
  - Response: no stall; `issue_valid` in t+1 and t+2; `wb_valid`/`wb_rd`=3 in t+1; `busy_mask`=0x08 in t+1 only.
- **MUL RAW:**
  - Stimulus: MUL 0xA rd=5 at t, then ALU rs2=5 (imm_flag=0) presented from t+1.
  - Response: `stall`=1 in t+1 and t+2; accepted at t+3; `wb_rd`=5 at t+3. Repeating with imm_flag=1 gives no stall.
- **WB conflict:**
  - Stimulus: MUL rd=1 at t, then LSU 0xC rd=2 presented at t+1.
  - Response: `stall`=1 at t+1; accepted at t+2; `wb_rd`=1 at t+3; `wb_rd`=2 at t+4.
- **Flush during stall:**
  - Stimulus: RAW-stalled ALU on r5 at t+1 with `is_branch_taken`=1.
  - Response: `stall`=0, `issue_valid`=0 at t+2, `busy_mask[5]` still set until the MUL writeback at t+3.
- **r0 and back-to-back MUL:**
  - r0 case: ALU rd=0, then ALU rs1=0 -> no stall, `busy_mask`=0, no `wb_valid`.
  - Back-to-back MUL case: two independent MULs -> second stalls 2 cycles.
